// File: rtl/uart_pkt_sequencer.sv
// Packet framer for the byte-wide UART transmitter: emits HEADER, LEN, payload
// bytes fetched from RAM, and an XOR checksum through the tx_wr/tx_busy handshake.
module uart_pkt_sequencer #(
  parameter int unsigned ADDR_W       = 8,
  parameter logic [7:0]  HEADER       = 8'hA5,
  parameter int unsigned GAP_CYCLES   = 1250,
  parameter int unsigned BUSY_TIMEOUT = 16
) (
  input  logic              clock_system,
  input  logic              rstn,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [7:0]        length,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_data,
  output logic [7:0]        tx_data,
  output logic              tx_wr,
  input  logic              tx_busy
);

  localparam int unsigned GAP_W = $clog2(GAP_CYCLES + 1);
  localparam int unsigned TMO_W = $clog2(BUSY_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LATCH,
    S_LOAD,
    S_WAIT_HI,
    S_WAIT_LO,
    S_GAP
  } state_t;

  typedef enum logic [1:0] {
    SEL_HDR,
    SEL_LEN,
    SEL_PAY,
    SEL_CSUM
  } sel_t;

  state_t            state, state_nxt;
  sel_t              sel, sel_nxt;
  logic [ADDR_W-1:0] base_q, base_nxt;
  logic [7:0]        len_q, len_nxt;
  logic [7:0]        idx, idx_nxt;
  logic [7:0]        csum, csum_nxt;
  logic [TMO_W-1:0]  tmo_cnt, tmo_nxt;
  logic [GAP_W-1:0]  gap_cnt, gap_nxt;

  logic              busy_nxt, done_nxt, err_nxt, mem_rd_nxt, tx_wr_nxt;
  logic [ADDR_W-1:0] mem_addr_nxt;
  logic [7:0]        tx_data_nxt;

  // State, datapath and registered outputs
  always_ff @(posedge clock_system or negedge rstn) begin
    if (!rstn) begin
      state    <= S_IDLE;
      sel      <= SEL_HDR;
      base_q   <= '0;
      len_q    <= '0;
      idx      <= '0;
      csum     <= '0;
      tmo_cnt  <= '0;
      gap_cnt  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      mem_rd   <= 1'b0;
      mem_addr <= '0;
      tx_data  <= '0;
      tx_wr    <= 1'b0;
    end else begin
      state    <= state_nxt;
      sel      <= sel_nxt;
      base_q   <= base_nxt;
      len_q    <= len_nxt;
      idx      <= idx_nxt;
      csum     <= csum_nxt;
      tmo_cnt  <= tmo_nxt;
      gap_cnt  <= gap_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
      err      <= err_nxt;
      mem_rd   <= mem_rd_nxt;
      mem_addr <= mem_addr_nxt;
      tx_data  <= tx_data_nxt;
      tx_wr    <= tx_wr_nxt;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_nxt    = state;
    sel_nxt      = sel;
    base_nxt     = base_q;
    len_nxt      = len_q;
    idx_nxt      = idx;
    csum_nxt     = csum;
    tmo_nxt      = tmo_cnt;
    gap_nxt      = gap_cnt;
    busy_nxt     = busy;
    done_nxt     = 1'b0;
    err_nxt      = 1'b0;
    mem_rd_nxt   = 1'b0;
    mem_addr_nxt = mem_addr;
    tx_data_nxt  = tx_data;
    tx_wr_nxt    = tx_wr;

    if ((state != S_IDLE) && abort) begin
      // A byte already handed to the transmitter is left to finish on its own
      state_nxt = S_IDLE;
      busy_nxt  = 1'b0;
      tx_wr_nxt = 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            base_nxt    = base_addr;
            len_nxt     = length;
            idx_nxt     = 8'd0;
            csum_nxt    = 8'd0;
            busy_nxt    = 1'b1;
            sel_nxt     = SEL_HDR;
            tx_data_nxt = HEADER;
            state_nxt   = S_LOAD;
          end
        end
        S_FETCH: state_nxt = S_LATCH;
        S_LATCH: begin
          tx_data_nxt = mem_data;
          csum_nxt    = csum ^ mem_data;
          idx_nxt     = idx + 8'd1;
          state_nxt   = S_LOAD;
        end
        S_LOAD: begin
          tx_wr_nxt = 1'b1;
          tmo_nxt   = '0;
          state_nxt = S_WAIT_HI;
        end
        S_WAIT_HI: begin
          if (tx_busy) begin
            tx_wr_nxt = 1'b0;
            state_nxt = S_WAIT_LO;
          end else if (tmo_cnt == TMO_W'(BUSY_TIMEOUT - 1)) begin
            tx_wr_nxt = 1'b0;
            err_nxt   = 1'b1;
            busy_nxt  = 1'b0;
            state_nxt = S_IDLE;
          end else begin
            tmo_nxt = tmo_cnt + TMO_W'(1);
          end
        end
        S_WAIT_LO: begin
          if (!tx_busy) begin
            gap_nxt   = '0;
            state_nxt = S_GAP;
          end
        end
        S_GAP: begin
          if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
            gap_nxt = '0;
            case (sel)
              SEL_HDR: begin
                sel_nxt     = SEL_LEN;
                tx_data_nxt = len_q;
                csum_nxt    = csum ^ len_q;
                state_nxt   = S_LOAD;
              end
              SEL_CSUM: begin
                done_nxt  = 1'b1;
                busy_nxt  = 1'b0;
                state_nxt = S_IDLE;
              end
              default: begin
                if (idx < len_q) begin
                  sel_nxt      = SEL_PAY;
                  mem_rd_nxt   = 1'b1;
                  mem_addr_nxt = base_q + ADDR_W'(idx);
                  state_nxt    = S_FETCH;
                end else begin
                  sel_nxt     = SEL_CSUM;
                  tx_data_nxt = csum;
                  state_nxt   = S_LOAD;
                end
              end
            endcase
          end else begin
            gap_nxt = gap_cnt + GAP_W'(1);
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_pkt_sequencer.sv
// Directed bench for uart_pkt_sequencer: RAM model, UART TX responder and
// per-scenario tasks with hand-computed byte streams.
module tb_uart_pkt_sequencer;

  localparam int unsigned GAP = 20;
  localparam int unsigned TMO = 16;

  logic       clock_system = 1'b0;
  logic       rstn, start, abort, tx_busy;
  logic [7:0] base_addr, length, mem_data, mem_addr, tx_data;
  logic       busy, done, err, mem_rd, tx_wr;

  logic [7:0] ram [256];
  logic [7:0] tx_log [$];
  logic [7:0] addr_log [$];
  int         done_cnt, err_cnt, both_cnt;
  bit         tx_en;
  int         pass_cnt, total_cnt;

  always #5 clock_system = ~clock_system;

  uart_pkt_sequencer #(
    .ADDR_W(8), .HEADER(8'hA5), .GAP_CYCLES(GAP), .BUSY_TIMEOUT(TMO)
  ) dut (
    .clock_system(clock_system), .rstn(rstn), .start(start),
    .base_addr(base_addr), .length(length), .abort(abort),
    .busy(busy), .done(done), .err(err), .mem_rd(mem_rd),
    .mem_addr(mem_addr), .mem_data(mem_data), .tx_data(tx_data),
    .tx_wr(tx_wr), .tx_busy(tx_busy)
  );

  // Synchronous-read RAM: data valid the cycle after mem_rd
  always @(posedge clock_system) if (mem_rd) mem_data <= ram[mem_addr];

  always @(negedge clock_system) begin
    if (done) done_cnt++;
    if (err) err_cnt++;
    if (done && err) both_cnt++;
    if (mem_rd) addr_log.push_back(mem_addr);
  end

  // Transmitter model: accepts a byte on tx_wr, stays busy for 5 cycles
  initial begin
    tx_busy = 1'b0;
    forever begin
      @(posedge clock_system); #1;
      if (tx_en && tx_wr && rstn) begin
        tx_log.push_back(tx_data);
        tx_busy = 1'b1;
        repeat (5) @(posedge clock_system);
        #1 tx_busy = 1'b0;
      end
    end
  end

  task automatic clear_logs();
    tx_log.delete();
    addr_log.delete();
    done_cnt = 0;
    err_cnt  = 0;
    both_cnt = 0;
  endtask

  task automatic pulse_start(input logic [7:0] b, input logic [7:0] l);
    @(posedge clock_system); #1;
    base_addr = b;
    length    = l;
    start     = 1'b1;
    @(posedge clock_system); #1;
    start     = 1'b0;
  endtask

  task automatic wait_end(input int bound, output bit timed_out);
    int k = 0;
    while (!(done || err) && k < bound) begin
      @(negedge clock_system);
      k++;
    end
    timed_out = (k >= bound);
    repeat (3) @(negedge clock_system);
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) @(negedge clock_system);
    total_cnt++;
    if ({busy, done, err, mem_rd, tx_wr, tx_data, mem_addr} !== 21'd0)
      $display("FAIL reset_outputs: got %b required all zero",
               {busy, done, err, mem_rd, tx_wr, tx_data, mem_addr});
    else pass_cnt++;
    rstn = 1'b1;
    repeat (2) @(negedge clock_system);
  endtask

  task automatic test_basic();
    logic [7:0] exp_tx [6] = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
    logic [7:0] exp_ad [3] = '{8'h10, 8'h11, 8'h12};
    logic [7:0] got;
    bit to;
    clear_logs();
    pulse_start(8'h10, 8'd3);
    total_cnt++;
    if (busy !== 1'b1) $display("FAIL basic_busy_high: got %b required 1", busy);
    else pass_cnt++;
    wait_end(5000, to);
    total_cnt++;
    if (to) $display("FAIL basic_timeout: got no done required done");
    else pass_cnt++;
    total_cnt++;
    if (tx_log.size() != 6) $display("FAIL basic_tx_count: got %0d required 6", tx_log.size());
    else pass_cnt++;
    for (int i = 0; i < 6; i++) begin
      got = (i < tx_log.size()) ? tx_log[i] : 8'hxx;
      total_cnt++;
      if (got !== exp_tx[i]) $display("FAIL basic_tx[%0d]: got %h required %h", i, got, exp_tx[i]);
      else pass_cnt++;
    end
    for (int i = 0; i < 3; i++) begin
      got = (i < addr_log.size()) ? addr_log[i] : 8'hxx;
      total_cnt++;
      if (got !== exp_ad[i]) $display("FAIL basic_addr[%0d]: got %h required %h", i, got, exp_ad[i]);
      else pass_cnt++;
    end
    total_cnt++;
    if (done_cnt !== 1 || err_cnt !== 0 || both_cnt !== 0 || busy !== 1'b0)
      $display("FAIL basic_status: got done=%0d err=%0d busy=%b required done=1 err=0 busy=0",
               done_cnt, err_cnt, busy);
    else pass_cnt++;
  endtask

  task automatic test_len_zero();
    logic [7:0] exp_tx [3] = '{8'hA5, 8'h00, 8'h00};
    logic [7:0] got;
    int k = 0;
    int lat = 0;
    clear_logs();
    pulse_start(8'h40, 8'd0);
    while (tx_log.size() < 3 && k < 5000) begin @(negedge clock_system); k++; end
    k = 0;
    while (tx_busy && k < 100) begin @(negedge clock_system); k++; end
    while (!done && lat < 1000) begin @(negedge clock_system); lat++; end
    total_cnt++;
    if (lat != GAP + 1) $display("FAIL len0_done_latency: got %0d required %0d", lat, GAP + 1);
    else pass_cnt++;
    repeat (3) @(negedge clock_system);
    for (int i = 0; i < 3; i++) begin
      got = (i < tx_log.size()) ? tx_log[i] : 8'hxx;
      total_cnt++;
      if (got !== exp_tx[i]) $display("FAIL len0_tx[%0d]: got %h required %h", i, got, exp_tx[i]);
      else pass_cnt++;
    end
    total_cnt++;
    if (tx_log.size() != 3 || addr_log.size() != 0 || done_cnt !== 1)
      $display("FAIL len0_status: got tx=%0d rd=%0d done=%0d required tx=3 rd=0 done=1",
               tx_log.size(), addr_log.size(), done_cnt);
    else pass_cnt++;
  endtask

  task automatic test_timeout();
    int k = 0;
    clear_logs();
    tx_en = 1'b0;
    pulse_start(8'h10, 8'd3);
    while (!tx_wr && k < 20) begin @(negedge clock_system); k++; end
    k = 0;
    while (!err && k < 100) begin @(negedge clock_system); k++; end
    total_cnt++;
    if (k != TMO) $display("FAIL timeout_err_delay: got %0d required %0d", k, TMO);
    else pass_cnt++;
    total_cnt++;
    if (busy !== 1'b0 || tx_wr !== 1'b0)
      $display("FAIL timeout_idle: got busy=%b tx_wr=%b required 0 0", busy, tx_wr);
    else pass_cnt++;
    repeat (50) @(negedge clock_system);
    total_cnt++;
    if (done_cnt !== 0 || err_cnt !== 1)
      $display("FAIL timeout_pulses: got done=%0d err=%0d required 0 1", done_cnt, err_cnt);
    else pass_cnt++;
    tx_en = 1'b1;
  endtask

  task automatic test_abort();
    int k = 0;
    clear_logs();
    pulse_start(8'h10, 8'd3);
    while (!(tx_log.size() == 4 && tx_busy && !tx_wr) && k < 5000) begin
      @(negedge clock_system);
      k++;
    end
    total_cnt++;
    if (k >= 5000) $display("FAIL abort_reach_wait_lo: got timeout required 2nd payload busy");
    else pass_cnt++;
    @(posedge clock_system); #1;
    abort = 1'b1;
    @(posedge clock_system); #1;
    abort = 1'b0;
    @(negedge clock_system);
    total_cnt++;
    if (busy !== 1'b0 || tx_wr !== 1'b0)
      $display("FAIL abort_idle: got busy=%b tx_wr=%b required 0 0", busy, tx_wr);
    else pass_cnt++;
    repeat (3 * GAP + 40) @(negedge clock_system);
    total_cnt++;
    if (tx_log.size() != 4 || done_cnt !== 0 || err_cnt !== 0)
      $display("FAIL abort_quiet: got tx=%0d done=%0d err=%0d required 4 0 0",
               tx_log.size(), done_cnt, err_cnt);
    else pass_cnt++;
  endtask

  task automatic test_restart_ignored();
    logic [7:0] exp_tx [6] = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
    logic [7:0] got;
    int k = 0;
    bit to;
    clear_logs();
    pulse_start(8'h10, 8'd3);
    while (tx_log.size() < 3 && k < 5000) begin @(negedge clock_system); k++; end
    pulse_start(8'hFE, 8'd4);
    wait_end(5000, to);
    for (int i = 0; i < 6; i++) begin
      got = (i < tx_log.size()) ? tx_log[i] : 8'hxx;
      total_cnt++;
      if (got !== exp_tx[i]) $display("FAIL restart_tx[%0d]: got %h required %h", i, got, exp_tx[i]);
      else pass_cnt++;
    end
    total_cnt++;
    if (to || tx_log.size() != 6 || addr_log.size() != 3 || done_cnt !== 1)
      $display("FAIL restart_status: got tx=%0d rd=%0d done=%0d required 6 3 1",
               tx_log.size(), addr_log.size(), done_cnt);
    else pass_cnt++;
  endtask

  task automatic test_addr_wrap();
    logic [7:0] exp_tx [7] = '{8'hA5, 8'h04, 8'h5A, 8'hC3, 8'h0F, 8'h81, 8'h13};
    logic [7:0] exp_ad [4] = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    logic [7:0] got;
    bit to;
    clear_logs();
    pulse_start(8'hFE, 8'd4);
    wait_end(5000, to);
    for (int i = 0; i < 4; i++) begin
      got = (i < addr_log.size()) ? addr_log[i] : 8'hxx;
      total_cnt++;
      if (got !== exp_ad[i]) $display("FAIL wrap_addr[%0d]: got %h required %h", i, got, exp_ad[i]);
      else pass_cnt++;
    end
    for (int i = 0; i < 7; i++) begin
      got = (i < tx_log.size()) ? tx_log[i] : 8'hxx;
      total_cnt++;
      if (got !== exp_tx[i]) $display("FAIL wrap_tx[%0d]: got %h required %h", i, got, exp_tx[i]);
      else pass_cnt++;
    end
    total_cnt++;
    if (to || done_cnt !== 1 || err_cnt !== 0)
      $display("FAIL wrap_status: got done=%0d err=%0d required 1 0", done_cnt, err_cnt);
    else pass_cnt++;
  endtask

  task automatic test_async_reset();
    int k = 0;
    clear_logs();
    pulse_start(8'h10, 8'd3);
    while (!mem_rd && k < 5000) begin @(negedge clock_system); k++; end
    #2 rstn = 1'b0;
    #1;
    total_cnt++;
    if (k >= 5000 || {busy, done, err, mem_rd, tx_wr, tx_data, mem_addr} !== 21'd0)
      $display("FAIL async_reset_outputs: got %b required all zero",
               {busy, done, err, mem_rd, tx_wr, tx_data, mem_addr});
    else pass_cnt++;
    repeat (5) @(negedge clock_system);
    rstn = 1'b1;
    repeat (10) @(negedge clock_system);
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    tx_en     = 1'b1;
    start     = 1'b0;
    abort     = 1'b0;
    base_addr = 8'h00;
    length    = 8'h00;
    for (int i = 0; i < 256; i++) ram[i] = 8'h00;
    ram[8'h10] = 8'h11;
    ram[8'h11] = 8'h22;
    ram[8'h12] = 8'h33;
    ram[8'hFE] = 8'h5A;
    ram[8'hFF] = 8'hC3;
    ram[8'h00] = 8'h0F;
    ram[8'h01] = 8'h81;
    clear_logs();

    test_reset();
    test_basic();
    test_len_zero();
    test_timeout();
    test_abort();
    test_restart_ignored();
    test_addr_wrap();
    test_async_reset();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
